// File: rtl/util_mon_pkg.sv
// Shared types for the utilisation monitor: FSM states, layer record layout, widths.
// Counters inside the record are carried at CNT_MAX_W; the block's CNT_W must not exceed it.
package util_mon_pkg;
  localparam int LAYER_ID_W = 8;
  localparam int CNT_MAX_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [CNT_MAX_W-1:0]  cycles;
    logic [CNT_MAX_W-1:0]  lane_cycles;
    logic [CNT_MAX_W-1:0]  full_cycles;
    logic [CNT_MAX_W-1:0]  wreq;
    logic [CNT_MAX_W-1:0]  ireq;
    logic                  mode;
    logic [LAYER_ID_W-1:0] layer_id;
  } mon_rec_t;

  localparam int REC_W = $bits(mon_rec_t);
endpackage

// File: rtl/util_monitor_if.sv
// Valid/ready record channel; master drives valid+data, slave returns ready.
interface util_monitor_if
  import util_mon_pkg::*;
#(
  parameter int W = REC_W
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/util_rec_fifo.sv
// Record buffer: power-of-2 depth, extra pointer bit for full/empty.
// Accepts a push while full when a pop retires the head in the same cycle.
module util_rec_fifo #(
  parameter int REC_W = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  util_monitor_if.slave  push,
  util_monitor_if.master pop
);
  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             full, empty, push_fire, pop_fire;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop.valid = !empty;
  // Gated so the record outputs read zero while nothing is buffered.
  assign pop.data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign pop_fire  = !empty && pop.ready;
  assign push.ready = !full || pop_fire;
  assign push_fire = push.valid && push.ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_fire) wr_q <= wr_q + 1'b1;
      if (pop_fire)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wr_q[AW-1:0]] <= push.data;
  end
endmodule

// File: rtl/util_monitor.sv
// Per-layer conv utilisation monitor: accumulates saturating activity counters
// between layer boundaries and queues one record per closed layer.
module util_monitor
  import util_mon_pkg::*;
#(
  parameter int NUM_LANES  = 9,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dataflow_en,
  input  logic [NUM_LANES-1:0]  conv_vld,
  input  logic                  weight_req,
  input  logic                  input_req,
  input  logic                  frame_mode,
  input  logic                  layer_start,
  input  logic                  layer_done,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [CNT_W-1:0]      rec_cycles,
  output logic [CNT_W-1:0]      rec_lane_cycles,
  output logic [CNT_W-1:0]      rec_full_cycles,
  output logic [CNT_W-1:0]      rec_wreq,
  output logic [CNT_W-1:0]      rec_ireq,
  output logic                  rec_mode,
  output logic [LAYER_ID_W-1:0] rec_layer_id,
  output logic                  busy,
  output logic                  proto_err,
  output logic [7:0]            drop_cnt
);
  localparam int PC_W = $clog2(NUM_LANES + 1);
  localparam int SW   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  b,
                                               input logic             load);
    logic [SW-1:0] s;
    s = (load ? '0 : SW'(a)) + SW'(b);
    return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  mon_state_e            state_q, state_d;
  logic                  pend_q, pend_d, pmode_q, pmode_d, mode_q, mode_d;
  logic                  first_q, first_d, err_q, err_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d, lane_q, lane_d, full_q, full_d;
  logic [CNT_W-1:0]      wreq_q, wreq_d, ireq_q, ireq_d;
  logic [LAYER_ID_W-1:0] lid_q, lid_d;
  logic [7:0]            drop_q, drop_d;
  logic                  cnt_en, load, flush;
  logic [PC_W-1:0]       pcnt;
  mon_rec_t              rec_push, rec_head;

  util_monitor_if #(.W(REC_W)) push_if ();
  util_monitor_if #(.W(REC_W)) pop_if ();

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < NUM_LANES; i++) pcnt = pcnt + PC_W'(conv_vld[i]);
  end

  // A start seen in RUN closes the open layer and parks the new one in pend_q;
  // it then begins with a load on the cycle after FLUSH (first_q).
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pmode_d = pmode_q;
    mode_d  = mode_q;
    first_d = 1'b0;
    err_d   = err_q;
    cnt_en  = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          cnt_en  = 1'b1;
          load    = 1'b1;
          mode_d  = frame_mode;
          state_d = layer_done ? ST_FLUSH : ST_RUN;
        end else if (layer_done) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        load   = first_q;
        if (layer_start) begin
          err_d   = 1'b1;
          pend_d  = 1'b1;
          pmode_d = frame_mode;
          state_d = ST_FLUSH;
        end else if (layer_done) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (layer_done) err_d = 1'b1;
        if (pend_q || layer_start) begin
          state_d = ST_RUN;
          first_d = 1'b1;
          pend_d  = 1'b0;
          mode_d  = layer_start ? frame_mode : pmode_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d  = cyc_q;
    lane_d = lane_q;
    full_d = full_q;
    wreq_d = wreq_q;
    ireq_d = ireq_q;
    if (cnt_en) begin
      cyc_d  = sat_add(cyc_q,  PC_W'(1), load);
      lane_d = sat_add(lane_q, dataflow_en ? pcnt : '0, load);
      full_d = sat_add(full_q, PC_W'(dataflow_en && (&conv_vld)), load);
      wreq_d = sat_add(wreq_q, PC_W'(weight_req), load);
      ireq_d = sat_add(ireq_q, PC_W'(input_req), load);
    end
  end

  assign flush  = (state_q == ST_FLUSH);
  assign lid_d  = flush ? lid_q + 1'b1 : lid_q;
  assign drop_d = (flush && !push_if.ready && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;

  always_comb begin
    rec_push = '{cycles:      CNT_MAX_W'(cyc_q),
                 lane_cycles: CNT_MAX_W'(lane_q),
                 full_cycles: CNT_MAX_W'(full_q),
                 wreq:        CNT_MAX_W'(wreq_q),
                 ireq:        CNT_MAX_W'(ireq_q),
                 mode:        mode_q,
                 layer_id:    lid_q};
  end

  assign push_if.valid = flush;
  assign push_if.data  = rec_push;
  assign pop_if.ready  = rec_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      pmode_q <= 1'b0;
      mode_q  <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cyc_q   <= '0;
      lane_q  <= '0;
      full_q  <= '0;
      wreq_q  <= '0;
      ireq_q  <= '0;
      lid_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      pmode_q <= pmode_d;
      mode_q  <= mode_d;
      first_q <= first_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      lane_q  <= lane_d;
      full_q  <= full_d;
      wreq_q  <= wreq_d;
      ireq_q  <= ireq_d;
      lid_q   <= lid_d;
      drop_q  <= drop_d;
    end
  end

  util_rec_fifo #(.REC_W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push_if.slave),
    .pop  (pop_if.master)
  );

  assign rec_head        = pop_if.data;
  assign rec_valid       = pop_if.valid;
  assign rec_cycles      = rec_head.cycles[CNT_W-1:0];
  assign rec_lane_cycles = rec_head.lane_cycles[CNT_W-1:0];
  assign rec_full_cycles = rec_head.full_cycles[CNT_W-1:0];
  assign rec_wreq        = rec_head.wreq[CNT_W-1:0];
  assign rec_ireq        = rec_head.ireq[CNT_W-1:0];
  assign rec_mode        = rec_head.mode;
  assign rec_layer_id    = rec_head.layer_id;
  assign busy            = (state_q != ST_IDLE);
  assign proto_err       = err_q;
  assign drop_cnt        = drop_q;
endmodule

// File: tb/tb_util_monitor.sv
// Scoreboarded bench: a default instance plus a CNT_W=4 instance on shared stimulus;
// expected records are queued at FLUSH time and popped on each record handshake.
module tb_util_monitor;
  import util_mon_pkg::*;

  localparam int NL    = 9;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          dataflow_en, weight_req, input_req, frame_mode, layer_start, layer_done;
  logic [NL-1:0] conv_vld;

  util_monitor_if #(.W(REC_W)) rec_bus ();

  logic [31:0] r_cyc, r_lane, r_full, r_wreq, r_ireq;
  logic        r_mode, busy, perr;
  logic [7:0]  r_lid, drop;
  logic [3:0]  s_cyc, s_lane, s_full, s_wreq, s_ireq;
  logic        s_valid, s_mode, s_busy, s_perr;
  logic [7:0]  s_lid, s_drop;

  assign rec_bus.data = {r_cyc, r_lane, r_full, r_wreq, r_ireq, r_mode, r_lid};

  util_monitor #(.NUM_LANES(NL), .CNT_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
    .weight_req(weight_req), .input_req(input_req), .frame_mode(frame_mode),
    .layer_start(layer_start), .layer_done(layer_done),
    .rec_valid(rec_bus.valid), .rec_ready(rec_bus.ready),
    .rec_cycles(r_cyc), .rec_lane_cycles(r_lane), .rec_full_cycles(r_full),
    .rec_wreq(r_wreq), .rec_ireq(r_ireq), .rec_mode(r_mode), .rec_layer_id(r_lid),
    .busy(busy), .proto_err(perr), .drop_cnt(drop)
  );

  util_monitor #(.NUM_LANES(NL), .CNT_W(4), .FIFO_DEPTH(DEPTH)) dut_sat (
    .clk(clk), .rstn(rstn), .dataflow_en(dataflow_en), .conv_vld(conv_vld),
    .weight_req(weight_req), .input_req(input_req), .frame_mode(frame_mode),
    .layer_start(layer_start), .layer_done(layer_done),
    .rec_valid(s_valid), .rec_ready(rec_bus.ready),
    .rec_cycles(s_cyc), .rec_lane_cycles(s_lane), .rec_full_cycles(s_full),
    .rec_wreq(s_wreq), .rec_ireq(s_ireq), .rec_mode(s_mode), .rec_layer_id(s_lid),
    .busy(s_busy), .proto_err(s_perr), .drop_cnt(s_drop)
  );

  typedef struct {
    int   cyc, lane, full, wreq, ireq;
    logic mode;
    int   lid;
  } exp_t;

  exp_t     sbq[$];
  exp_t     mon_e;
  mon_rec_t mon_h;
  int       n_chk = 0, n_fail = 0, n_pop = 0, exp_lid = 0, exp_drop = 0, pop_base;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  always @(negedge clk) begin
    if (rstn && rec_bus.valid && rec_bus.ready) begin
      n_pop++;
      mon_h = rec_bus.data;
      if (sbq.size() == 0) begin
        chk("unexpected_record", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rec_cycles",      mon_h.cycles,      mon_e.cyc);
        chk("rec_lane_cycles", mon_h.lane_cycles, mon_e.lane);
        chk("rec_full_cycles", mon_h.full_cycles, mon_e.full);
        chk("rec_wreq",        mon_h.wreq,        mon_e.wreq);
        chk("rec_ireq",        mon_h.ireq,        mon_e.ireq);
        chk("rec_mode",        mon_h.mode,        mon_e.mode);
        chk("rec_layer_id",    mon_h.layer_id,    mon_e.lid);
        chk("sat_valid",       s_valid,           1);
        chk("sat_cycles",      s_cyc,             sat4(mon_e.cyc));
        chk("sat_lane_cycles", s_lane,            sat4(mon_e.lane));
        chk("sat_full_cycles", s_full,            sat4(mon_e.full));
        chk("sat_wreq",        s_wreq,            sat4(mon_e.wreq));
        chk("sat_ireq",        s_ireq,            sat4(mon_e.ireq));
        chk("sat_mode",        s_mode,            mon_e.mode);
        chk("sat_layer_id",    s_lid,             mon_e.lid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    layer_start = 1'b0; layer_done = 1'b0; dataflow_en = 1'b0;
    conv_vld = '0; weight_req = 1'b0; input_req = 1'b0;
  endtask

  // Called during the FLUSH cycle: queue occupancy here equals the DUT FIFO's.
  task automatic push_exp(input int cyc, input int lane, input int full,
                          input int wreq, input int ireq, input logic mode);
    exp_t e;
    if (sbq.size() >= DEPTH && !rec_bus.ready) begin
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end else begin
      e = '{cyc: cyc, lane: lane, full: full, wreq: wreq, ireq: ireq, mode: mode, lid: exp_lid};
      sbq.push_back(e);
    end
    exp_lid = (exp_lid + 1) % 256;
  endtask

  task automatic run_layer(input int n, input logic en, input logic [NL-1:0] v,
                           input logic wr, input logic ir, input logic md, input logic flush_rdy);
    logic keep_rdy;
    keep_rdy = rec_bus.ready;
    for (int i = 0; i < n; i++) begin
      layer_start = (i == 0); layer_done = (i == n - 1); frame_mode = md;
      dataflow_en = en; conv_vld = v; weight_req = wr; input_req = ir;
      step();
    end
    idle_in();
    rec_bus.ready = flush_rdy;
    chk("busy_flush", busy, 1);
    push_exp(n, en ? n * $countones(v) : 0, (en && (&v)) ? n : 0, wr ? n : 0, ir ? n : 0, md);
    step();
    rec_bus.ready = keep_rdy;
  endtask

  task automatic check_status(input logic e_busy, input logic e_err, input int e_drop);
    chk("busy",          busy,   e_busy);
    chk("proto_err",     perr,   e_err);
    chk("drop_cnt",      drop,   e_drop);
    chk("sat_busy",      s_busy, e_busy);
    chk("sat_proto_err", s_perr, e_err);
    chk("sat_drop_cnt",  s_drop, e_drop);
  endtask

  task automatic do_reset();
    idle_in();
    rec_bus.ready = 1'b0;
    rstn = 1'b0;
    step();
    sbq.delete();
    exp_lid = 0;
    exp_drop = 0;
    rstn = 1'b1;
    step();
  endtask

  task automatic drain();
    rec_bus.ready = 1'b1;
    for (int i = 0; i < 60 && sbq.size() != 0; i++) step();
    chk("drain_left", sbq.size(), 0);
    chk("drain_valid", rec_bus.valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    frame_mode = 1'b0;
    rec_bus.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  rec_bus.valid, 0);
    chk("rst_cycles", r_cyc, 0);
    chk("rst_lid",    r_lid, 0);
    check_status(0, 0, 0);
    rstn = 1'b1;
    step();

    // full-utilisation layer, then varied activity mixes
    rec_bus.ready = 1'b1;
    run_layer(10, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_layer(7,  1'b0, 9'h0F3, 1'b1, 1'b0, 1'b1, 1'b1);
    run_layer(4,  1'b1, 9'h155, 1'b0, 1'b1, 1'b0, 1'b1);
    run_layer(1,  1'b1, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1);
    run_layer(20, 1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();
    check_status(0, 0, 0);

    // back-pressure: 5 layers into a 4-deep buffer, then a push racing a pop
    do_reset();
    repeat (5) run_layer(2, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_status(0, 0, 1);
    chk("head_valid", rec_bus.valid, 1);
    chk("head_lid",   r_lid, 0);
    chk("head_cyc",   r_cyc, 2);
    repeat (3) step();
    chk("hold_lid",  r_lid, 0);
    chk("hold_lane", r_lane, 16);
    run_layer(3, 1'b1, 9'h001, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status(0, 0, 1);
    pop_base = n_pop;
    drain();
    chk("fifo_count", n_pop - pop_base, 4);

    // layer_done while idle is flagged and ignored
    do_reset();
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    step();
    check_status(0, 1, 0);
    chk("idle_done_valid", rec_bus.valid, 0);

    // layer_start in RUN cycle 3 closes the layer; pending layer carries its mode
    do_reset();
    rec_bus.ready = 1'b1;
    layer_start = 1'b1; dataflow_en = 1'b1; conv_vld = 9'h1FF; frame_mode = 1'b0;
    step();
    layer_start = 1'b0;
    step();
    layer_start = 1'b1; frame_mode = 1'b1;
    step();
    idle_in();
    frame_mode = 1'b0;
    chk("err_flush_busy", busy, 1);
    chk("err_flag", perr, 1);
    push_exp(3, 27, 3, 0, 0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      dataflow_en = 1'b1; conv_vld = 9'h003; layer_done = (i == 3);
      step();
    end
    idle_in();
    push_exp(4, 8, 0, 0, 0, 1'b1);
    step();
    drain();
    check_status(0, 1, 0);

    // reset in RUN cycle 5 discards the open layer
    do_reset();
    rec_bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      layer_start = (i == 0); dataflow_en = 1'b1; conv_vld = 9'h1FF;
      if (i < 4) step();
    end
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy",  busy, 0);
    chk("rst_mid_sbusy", s_busy, 0);
    chk("rst_mid_valid", rec_bus.valid, 0);
    idle_in();
    step();
    rstn = 1'b1;
    repeat (5) step();
    chk("rst_mid_after_valid", rec_bus.valid, 0);
    check_status(0, 0, 0);

    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
